ir_nec_rx_fifo: RTL and testbench
=================================

Name: ir_nec_rx_fifo

Overview:
- Parametrised successor to the single-code IR receiver in the IR/LCD kernel.
- Decodes NEC-format frames from the demodulated IR receiver pin.
- Adds repeat-code detection, optional address/command inverse checking, a decoded-code FIFO with a valid/ready output, an overflow flag and an error counter.
- Sits between the board IR pin and the Avalon slave wrapper; the CPU drains codes to drive the LCD.

Parameters:
CLK_HZ, 50000000, system clock frequency; prescaler divides to a 10 us tick, TICK_DIV = CLK_HZ/100000.
FIFO_DEPTH, 8, decoded-code entries, power of two, 2..64.
IR_ACTIVE_LOW, 1, 1 = pin idles high and a pulse is low (standard receiver module).
CHECK_INV, 1, 1 = reject a frame unless byte1 == ~byte0 and byte3 == ~byte2.
TIMEOUT_TICKS, 1200, ticks in any one level before the decoder aborts to IDLE.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
ir  in  1  raw IR receiver output, asynchronous
code_data  out  32  FIFO head: {cmd_n, cmd, addr_n, addr}, first received bit in LSB
code_repeat  out  1  FIFO head is a repeat code; code_data then holds the last good frame
code_valid  out  1  FIFO non-empty
code_ready  in  1  consumer pops head when code_valid & code_ready
fifo_level  out  $clog2(FIFO_DEPTH+1)  entries held
overflow  out  1  sticky: a code was dropped because the FIFO was full
err_count  out  8  saturating count of rejected frames
clr  in  1  clears overflow and err_count
busy  out  1  decoder not in IDLE

Behaviour:
- Input path: 2-flop synchroniser, then polarity normalised so 1 = pulse active. Edge detect on the normalised level. ir is ignored for 2 cycles after reset.
- Tick: prescaler counts 0..TICK_DIV-1 and pulses tick for one cycle. Duration counter counts ticks since the last edge, clears on every edge, saturates at TIMEOUT_TICKS.
- Decoder FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, REP_MARK.
  - IDLE: active edge -> LEAD_MARK.
  - LEAD_MARK: on the falling edge of the pulse, dur 800..1000 -> LEAD_SPACE; otherwise error -> IDLE.
  - LEAD_SPACE: on the active edge, dur 400..500 -> BIT_MARK with bit_cnt=0; dur 180..270 -> REP_MARK; otherwise error -> IDLE.
  - BIT_MARK: on pulse end, dur 40..72 -> BIT_SPACE; otherwise error.
  - BIT_SPACE: on the active edge, dur 40..84 shifts in 0, dur 130..210 shifts in 1, otherwise error. The shift enters at bit 31 and shifts right. bit_cnt==31 -> frame complete (final stop mark is not checked) -> IDLE; otherwise -> BIT_MARK.
  - REP_MARK: on pulse end, dur 40..72 -> repeat complete -> IDLE; otherwise error.
  - Any state except IDLE: dur reaches TIMEOUT_TICKS -> error -> IDLE.
- Frame complete:
  - If CHECK_INV=1 and the inverse check fails -> error.
  - Else push {data, repeat=0} and store data in last_code with last_ok=1.
- Repeat complete:
  - Push {last_code, repeat=1} if last_ok.
  - Else error.
  - last_ok clears on any error or timeout.
- Error: err_count += 1, saturating at 255. Exactly one increment per aborted frame.
- FIFO:
  - Circular buffer of FIFO_DEPTH x 33 bits; head is combinationally presented, first-word fall-through.
  - Push when full: the entry is dropped, overflow is set, existing contents are untouched.
  - Push and pop in the same cycle when full: the pop frees the slot, so the push is accepted and overflow is not set.
  - Push into an empty FIFO: code_valid rises the next cycle.
  - code_ready while empty is ignored.
- clr in the same cycle as an error or overflow event: the set/increment wins.
- Reset values:
  - FSM=IDLE, FIFO empty, code_valid=0, code_data=0, code_repeat=0, fifo_level=0.
  - overflow=0, err_count=0, busy=0, last_ok=0, prescaler=0.
- Reset asserted mid-frame aborts the frame with no push and no err_count increment.

Test Plan:
1. Frame addr=0x00, cmd=0x45 (code_data 0xBA45FF00) at CLK_HZ=50 MHz, consumer ready -> one push; code_valid high; code_data=0xBA45FF00; code_repeat=0; err_count=0.
2. Same frame, then 2 repeat codes, code_ready=0 -> fifo_level=3; entries 2 and 3 carry 0xBA45FF00 with code_repeat=1.
3. Repeat code with no prior frame, and a frame with cmd_n corrupted to 0xBB, CHECK_INV=1 -> no push; err_count=2. The same corrupt frame with CHECK_INV=1 then CHECK_INV=0 -> CHECK_INV=0 pushes 0xBB45FF00.
4. 10 frames, FIFO_DEPTH=8, code_ready=0 -> fifo_level=8; overflow=1; the first 8 codes pop in order. Pop coincident with a push at full -> overflow stays 0.
5. Leader then pin held idle for 15 ms -> timeout; busy falls; err_count=1. clr coincident with a new error -> err_count=2, not 0.
6. Reset asserted after 16 bits received -> no push; err_count=0. A clean frame afterwards decodes correctly. IR_ACTIVE_LOW=0 with an inverted stimulus -> identical results.

Source files
------------

// File: rtl/ir_nec_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ir_nec_rx_fifo
// Description : NEC infrared frame receiver with repeat-code detection,
//               optional address/command inverse checking, a first-word
//               fall-through FIFO of decoded codes, sticky overflow flag and
//               saturating error counter.
// Ports       : clk, reset      - system clock, synchronous active-high reset
//               ir              - raw (asynchronous) IR receiver output
//               code_data       - FIFO head {cmd_n, cmd, addr_n, addr}
//               code_repeat     - FIFO head is a repeat code
//               code_valid      - FIFO non-empty
//               code_ready      - pop head when code_valid & code_ready
//               fifo_level      - number of entries held
//               overflow        - sticky, a code was dropped while full
//               err_count       - saturating count of rejected frames
//               clr             - clears overflow and err_count
//               busy            - decoder is inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
module ir_nec_rx_fifo #(
  parameter int CLK_HZ        = 50000000,
  parameter int FIFO_DEPTH    = 8,
  parameter int IR_ACTIVE_LOW = 1,
  parameter int CHECK_INV     = 1,
  parameter int TIMEOUT_TICKS = 1200
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ir,
  output logic [31:0]                       code_data,
  output logic                              code_repeat,
  output logic                              code_valid,
  input  logic                              code_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overflow,
  output logic [7:0]                        err_count,
  input  logic                              clr,
  output logic                              busy
);

  localparam int   TICK_DIV = CLK_HZ / 100000;
  localparam int   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int   DW       = $clog2(TIMEOUT_TICKS + 1);
  localparam int   AW       = $clog2(FIFO_DEPTH);
  localparam int   LW       = $clog2(FIFO_DEPTH + 1);
  localparam logic IDLE_LVL = (IR_ACTIVE_LOW != 0);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
    S_REP_MARK   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q, lvl_prev_q;
  logic [1:0]      ign_q, ign_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   dur_q, dur_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [31:0]     shreg_q, shreg_d;
  logic [31:0]     last_code_q, last_code_d;
  logic            last_ok_q, last_ok_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      err_q, err_d;
  logic [32:0]     mem_q [FIFO_DEPTH];

  logic            lvl, armed, act_edge, fall_edge, tick, timeout;
  logic [31:0]     dur_w;
  logic            frame_done, rep_done, fsm_err, new_bit, inv_ok;
  logic            push_req, push_ok, pop, full, empty, err_evt;
  logic [32:0]     push_word;

  function automatic logic in_rng(input logic [31:0] d, input int lo, input int hi);
    return (d >= 32'(lo)) && (d <= 32'(hi));
  endfunction

  // Normalised level: 1 while an IR pulse is active, whatever the pin polarity.
  assign lvl       = sync2_q ^ IDLE_LVL;
  // Edges are masked until the synchroniser has flushed post-reset contents.
  assign armed     = (ign_q == 2'd2);
  assign act_edge  = armed & lvl & ~lvl_prev_q;
  assign fall_edge = armed & ~lvl & lvl_prev_q;
  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign dur_w     = 32'(dur_q);
  assign timeout   = (dur_w >= 32'(TIMEOUT_TICKS));
  assign inv_ok    = (shreg_d[15:8] == ~shreg_d[7:0]) && (shreg_d[31:24] == ~shreg_d[23:16]);

  // Input conditioning, prescaler and duration counter.
  always_comb begin
    ign_d   = (ign_q == 2'd2) ? ign_q : ign_q + 2'd1;
    presc_d = tick ? '0 : presc_q + PW'(1);
    dur_d   = dur_q;
    if (act_edge || fall_edge) begin
      dur_d = '0;
    end else if (tick && (dur_q != DW'(TIMEOUT_TICKS))) begin
      dur_d = dur_q + DW'(1);
    end
  end

  // Decoder: every measurement is made at the edge that ends a level.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    frame_done = 1'b0;
    rep_done   = 1'b0;
    fsm_err    = 1'b0;
    new_bit    = 1'b0;
    if ((state_q != S_IDLE) && timeout) begin
      fsm_err = 1'b1;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (act_edge) state_d = S_LEAD_MARK;
        end
        S_LEAD_MARK: begin
          if (fall_edge) begin
            if (in_rng(dur_w, 800, 1000)) state_d = S_LEAD_SPACE;
            else begin fsm_err = 1'b1; state_d = S_IDLE; end
          end
        end
        S_LEAD_SPACE: begin
          if (act_edge) begin
            if (in_rng(dur_w, 400, 500)) begin
              state_d   = S_BIT_MARK;
              bit_cnt_d = '0;
            end else if (in_rng(dur_w, 180, 270)) begin
              state_d = S_REP_MARK;
            end else begin
              fsm_err = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_BIT_MARK: begin
          if (fall_edge) begin
            if (in_rng(dur_w, 40, 72)) state_d = S_BIT_SPACE;
            else begin fsm_err = 1'b1; state_d = S_IDLE; end
          end
        end
        S_BIT_SPACE: begin
          if (act_edge) begin
            if (in_rng(dur_w, 40, 84) || in_rng(dur_w, 130, 210)) begin
              new_bit = in_rng(dur_w, 130, 210);
              // Shift right so the first received bit ends up in bit 0.
              shreg_d = {new_bit, shreg_q[31:1]};
              if (bit_cnt_q == 5'd31) begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
              end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
                state_d   = S_BIT_MARK;
              end
            end else begin
              fsm_err = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_REP_MARK: begin
          if (fall_edge) begin
            if (in_rng(dur_w, 40, 72)) rep_done = 1'b1;
            else fsm_err = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Frame/repeat completion, FIFO bookkeeping and status counters.
  always_comb begin
    push_req    = 1'b0;
    push_word   = '0;
    err_evt     = fsm_err;
    last_code_d = last_code_q;
    last_ok_d   = last_ok_q;
    if (frame_done) begin
      if ((CHECK_INV != 0) && !inv_ok) begin
        err_evt = 1'b1;
      end else begin
        push_req    = 1'b1;
        push_word   = {1'b0, shreg_d};
        last_code_d = shreg_d;
        last_ok_d   = 1'b1;
      end
    end
    if (rep_done) begin
      if (last_ok_q) begin
        push_req  = 1'b1;
        push_word = {1'b1, last_code_q};
      end else begin
        err_evt = 1'b1;
      end
    end
    if (err_evt) last_ok_d = 1'b0;

    empty   = (level_q == '0);
    full    = (level_q == LW'(FIFO_DEPTH));
    pop     = code_ready & ~empty;
    // A pop in the same cycle frees the slot for a push at full.
    push_ok = push_req & (~full | pop);

    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push_ok) - LW'(pop);

    // Set/increment takes priority over a coincident clear.
    overflow_d = overflow_q;
    if (push_req && !push_ok) overflow_d = 1'b1;
    else if (clr)             overflow_d = 1'b0;

    err_d = err_q;
    if (err_evt)  err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    else if (clr) err_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= IDLE_LVL;
      sync2_q     <= IDLE_LVL;
      lvl_prev_q  <= 1'b0;
      ign_q       <= '0;
      presc_q     <= '0;
      dur_q       <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      last_code_q <= '0;
      last_ok_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= ir;
      sync2_q     <= sync1_q;
      lvl_prev_q  <= lvl;
      ign_q       <= ign_d;
      presc_q     <= presc_d;
      dur_q       <= dur_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      last_code_q <= last_code_d;
      last_ok_q   <= last_ok_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      err_q       <= err_d;
    end
  end

  // Storage needs no reset: the head is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  assign {code_repeat, code_data} = empty ? 33'd0 : mem_q[rd_ptr_q];
  assign code_valid = ~empty;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign err_count  = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ir_nec_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_nec_rx_fifo
// Description : Self-checking bench for ir_nec_rx_fifo. Three receivers share
//               one pulse stream: the main one (active-low pin, inverse check
//               on), one with the inverse check off, and one with an
//               active-high pin fed the inverted waveform.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_nec_rx_fifo;

  localparam int CLK_HZ = 100000;  // one 10 us tick per clock keeps frames short
  localparam int DEPTH  = 8;
  localparam int LW     = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ir_act = 1'b0;  // 1 while an IR pulse is being sent
  logic ir_pin;
  logic code_ready = 1'b0;
  logic clr = 1'b0;

  assign ir_pin = ~ir_act;
  always #5 clk = ~clk;

  logic [31:0] m_data, n_data, h_data;
  logic m_rep, n_rep, h_rep, m_valid, n_valid, h_valid;
  logic [LW-1:0] m_level, n_level, h_level;
  logic m_ovf, n_ovf, h_ovf, m_busy, n_busy, h_busy;
  logic [7:0] m_errc, n_errc, h_errc;

  ir_nec_rx_fifo #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH), .IR_ACTIVE_LOW(1), .CHECK_INV(1), .TIMEOUT_TICKS(1200)) dut (
    .clk(clk), .reset(reset), .ir(ir_pin), .code_data(m_data), .code_repeat(m_rep),
    .code_valid(m_valid), .code_ready(code_ready), .fifo_level(m_level), .overflow(m_ovf),
    .err_count(m_errc), .clr(clr), .busy(m_busy));

  ir_nec_rx_fifo #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH), .IR_ACTIVE_LOW(1), .CHECK_INV(0), .TIMEOUT_TICKS(1200)) dut_noinv (
    .clk(clk), .reset(reset), .ir(ir_pin), .code_data(n_data), .code_repeat(n_rep),
    .code_valid(n_valid), .code_ready(1'b1), .fifo_level(n_level), .overflow(n_ovf),
    .err_count(n_errc), .clr(clr), .busy(n_busy));

  ir_nec_rx_fifo #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH), .IR_ACTIVE_LOW(0), .CHECK_INV(1), .TIMEOUT_TICKS(1200)) dut_hi (
    .clk(clk), .reset(reset), .ir(ir_act), .code_data(h_data), .code_repeat(h_rep),
    .code_valid(h_valid), .code_ready(code_ready), .fifo_level(h_level), .overflow(h_ovf),
    .err_count(h_errc), .clr(clr), .busy(h_busy));

  int errors = 0;
  int checks = 0;

  // Reference model of the main receiver's observable state.
  logic [32:0] exp_q[$];
  int          exp_err = 0;
  logic        exp_ovf = 1'b0;
  logic [31:0] exp_last = '0;
  logic        exp_last_ok = 1'b0;

  // Everything the always-ready inverse-check-off receiver hands out.
  logic [32:0] nq[$];
  always @(posedge clk) if (!reset && n_valid) nq.push_back({n_rep, n_data});

  task automatic model_push(input logic [32:0] w);
    if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(w);
  endtask

  task automatic model_error();
    if (exp_err < 255) exp_err++;
    exp_last_ok = 1'b0;
  endtask

  task automatic model_frame(input logic [31:0] d);
    // A byte and its complement always sum to 255.
    if ((int'(d[7:0]) + int'(d[15:8]) != 255) || (int'(d[23:16]) + int'(d[31:24]) != 255)) begin
      model_error();
    end else begin
      model_push({1'b0, d});
      exp_last    = d;
      exp_last_ok = 1'b1;
    end
  endtask

  task automatic model_repeat();
    if (exp_last_ok) model_push({1'b1, exp_last});
    else model_error();
  endtask

  function automatic logic [31:0] good_code();
    logic [7:0] a, c;
    a = 8'($urandom);
    c = 8'($urandom);
    return {8'(255 - int'(c)), c, 8'(255 - int'(a)), a};
  endfunction

  task automatic hold(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bits(input logic [31:0] d, input int nbits);
    ir_act = 1'b1; hold(int'($urandom_range(830, 810)));
    ir_act = 1'b0; hold(int'($urandom_range(420, 405)));
    for (int i = 0; i < nbits; i++) begin
      ir_act = 1'b1; hold(int'($urandom_range(60, 45)));
      ir_act = 1'b0;
      if (d[i]) hold(int'($urandom_range(150, 135)));
      else      hold(int'($urandom_range(60, 45)));
    end
    if (nbits == 32) begin
      ir_act = 1'b1; hold(50);
      ir_act = 1'b0; hold(100);
    end
  endtask

  // With pop_at_end the consumer pops in exactly the cycle the repeat is pushed
  // (pulse end + two synchroniser stages).
  task automatic send_repeat(input logic pop_at_end);
    ir_act = 1'b1; hold(int'($urandom_range(830, 810)));
    ir_act = 1'b0; hold(int'($urandom_range(250, 200)));
    ir_act = 1'b1; hold(int'($urandom_range(60, 45)));
    ir_act = 1'b0;
    if (pop_at_end) begin
      hold(2); code_ready = 1'b1; hold(1); code_ready = 1'b0;
    end
    hold(100);
  endtask

  task automatic do_reset();
    reset = 1'b1; ir_act = 1'b0; code_ready = 1'b0; clr = 1'b0;
    hold(3);
    reset = 1'b0;
    hold(3);
    exp_q.delete(); nq.delete();
    exp_err = 0; exp_ovf = 1'b0; exp_last = '0; exp_last_ok = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({m_valid, m_rep, m_data} !== 34'd0) begin errors++; $display("FAIL reset_head: got %h expected 0", {m_valid, m_rep, m_data}); end
    checks++; if ({m_level, m_ovf, m_busy, m_errc} !== '0) begin errors++; $display("FAIL reset_status: got lvl=%0d ovf=%b busy=%b err=%0d expected all 0", m_level, m_ovf, m_busy, m_errc); end
    checks++; if ({h_valid, h_level, h_errc, h_busy} !== '0) begin errors++; $display("FAIL reset_hi: got valid=%b lvl=%0d err=%0d busy=%b expected all 0", h_valid, h_level, h_errc, h_busy); end
  endtask

  task automatic test_single_frame();
    logic [32:0] w;
    do_reset();
    send_bits(32'hBA45FF00, 32); model_frame(32'hBA45FF00);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL frame_valid: got %b expected 1", m_valid); end
    checks++; if ({m_rep, m_data} !== exp_q[0]) begin errors++; $display("FAIL frame_head: got %h expected %h", {m_rep, m_data}, exp_q[0]); end
    checks++; if ({m_errc, m_busy} !== {8'(exp_err), 1'b0}) begin errors++; $display("FAIL frame_err: got err=%0d busy=%b expected err=%0d busy=0", m_errc, m_busy, exp_err); end
    checks++; if ({h_rep, h_data} !== exp_q[0]) begin errors++; $display("FAIL frame_hi_head: got %h expected %h", {h_rep, h_data}, exp_q[0]); end
    code_ready = 1'b1; hold(1); code_ready = 1'b0;
    w = exp_q.pop_front();
    // Ready while empty must not underflow.
    code_ready = 1'b1; hold(3); code_ready = 1'b0;
    checks++; if ({m_valid, m_level} !== {1'b0, LW'(exp_q.size())}) begin errors++; $display("FAIL frame_drain: got valid=%b lvl=%0d expected valid=0 lvl=%0d (last %h)", m_valid, m_level, exp_q.size(), w); end
  endtask

  task automatic test_repeat_codes();
    logic [32:0] w;
    do_reset();
    send_bits(32'hBA45FF00, 32); model_frame(32'hBA45FF00);
    repeat (2) begin send_repeat(1'b0); model_repeat(); end
    checks++; if (m_level !== LW'(exp_q.size())) begin errors++; $display("FAIL rep_level: got %0d expected %0d", m_level, exp_q.size()); end
    for (int i = 0; i < 3; i++) begin
      w = exp_q.pop_front();
      checks++; if ({m_valid, m_rep, m_data} !== {1'b1, w}) begin errors++; $display("FAIL rep_entry%0d: got v=%b %h expected v=1 %h", i, m_valid, {m_rep, m_data}, w); end
      code_ready = 1'b1; hold(1); code_ready = 1'b0;
    end
  endtask

  task automatic test_inverse_check();
    do_reset();
    send_repeat(1'b0); model_repeat();
    checks++; if ({m_errc, m_level} !== {8'(exp_err), LW'(exp_q.size())}) begin errors++; $display("FAIL orphan_repeat: got err=%0d lvl=%0d expected err=%0d lvl=%0d", m_errc, m_level, exp_err, exp_q.size()); end
    send_bits(32'hBB45FF00, 32); model_frame(32'hBB45FF00);
    checks++; if ({m_errc, m_level} !== {8'(exp_err), LW'(exp_q.size())}) begin errors++; $display("FAIL bad_inverse: got err=%0d lvl=%0d expected err=%0d lvl=%0d", m_errc, m_level, exp_err, exp_q.size()); end
    checks++; if (nq.size() !== 1) begin errors++; $display("FAIL noinv_count: got %0d expected 1", nq.size()); end
    checks++; if (nq[0] !== {1'b0, 32'hBB45FF00}) begin errors++; $display("FAIL noinv_code: got %h expected %h", nq[0], {1'b0, 32'hBB45FF00}); end
    checks++; if (n_errc !== 8'd1) begin errors++; $display("FAIL noinv_err: got %0d expected 1", n_errc); end
  endtask

  task automatic test_overflow();
    logic [32:0] w;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 4) begin d = good_code(); send_bits(d, 32); model_frame(d); end
      else begin send_repeat(1'b0); model_repeat(); end
    end
    checks++; if ({m_level, m_ovf} !== {LW'(exp_q.size()), exp_ovf}) begin errors++; $display("FAIL ovf_full: got lvl=%0d ovf=%b expected lvl=%0d ovf=%b", m_level, m_ovf, exp_q.size(), exp_ovf); end
    checks++; if ({h_level, h_ovf} !== {LW'(exp_q.size()), exp_ovf}) begin errors++; $display("FAIL ovf_hi: got lvl=%0d ovf=%b expected lvl=%0d ovf=%b", h_level, h_ovf, exp_q.size(), exp_ovf); end
    clr = 1'b1; hold(1); clr = 1'b0;
    exp_ovf = 1'b0; exp_err = 0;
    checks++; if (m_ovf !== exp_ovf) begin errors++; $display("FAIL ovf_clr: got %b expected %b", m_ovf, exp_ovf); end
    send_repeat(1'b1);
    w = exp_q.pop_front(); model_repeat();
    checks++; if ({m_level, m_ovf} !== {LW'(exp_q.size()), exp_ovf}) begin errors++; $display("FAIL pop_push_full: got lvl=%0d ovf=%b expected lvl=%0d ovf=%b", m_level, m_ovf, exp_q.size(), exp_ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      w = exp_q.pop_front();
      checks++; if ({m_valid, m_rep, m_data} !== {1'b1, w}) begin errors++; $display("FAIL ovf_order%0d: got v=%b %h expected v=1 %h", i, m_valid, {m_rep, m_data}, w); end
      code_ready = 1'b1; hold(1); code_ready = 1'b0;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    ir_act = 1'b1; hold(815);
    ir_act = 1'b0; hold(10);
    checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL to_busy: got %b expected 1", m_busy); end
    hold(1250); model_error();
    checks++; if ({m_busy, m_errc, m_level} !== {1'b0, 8'(exp_err), LW'(0)}) begin errors++; $display("FAIL timeout: got busy=%b err=%0d lvl=%0d expected busy=0 err=%0d lvl=0", m_busy, m_errc, m_level, exp_err); end
    checks++; if (h_errc !== 8'(exp_err)) begin errors++; $display("FAIL timeout_hi: got %0d expected %0d", h_errc, exp_err); end
    // Too-short leader: the error is raised as the pulse end is seen, with clr high.
    ir_act = 1'b1; hold(300);
    ir_act = 1'b0; hold(2); clr = 1'b1; hold(1); clr = 1'b0; hold(10);
    model_error();
    checks++; if (m_errc !== 8'(exp_err)) begin errors++; $display("FAIL clr_vs_err: got %0d expected %0d", m_errc, exp_err); end
    clr = 1'b1; hold(1); clr = 1'b0; exp_err = 0;
    checks++; if (m_errc !== 8'(exp_err)) begin errors++; $display("FAIL clr_only: got %0d expected %0d", m_errc, exp_err); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    do_reset();
    send_bits(good_code(), 16);
    hold(5); reset = 1'b1; hold(3); reset = 1'b0; hold(3);
    checks++; if ({m_level, m_errc, m_busy} !== '0) begin errors++; $display("FAIL mid_reset: got lvl=%0d err=%0d busy=%b expected all 0", m_level, m_errc, m_busy); end
    checks++; if (nq.size() !== 0) begin errors++; $display("FAIL mid_reset_noinv: got %0d codes expected 0", nq.size()); end
    d = good_code(); send_bits(d, 32); model_frame(d);
    checks++; if ({m_valid, m_rep, m_data} !== {1'b1, exp_q[0]}) begin errors++; $display("FAIL post_reset: got v=%b %h expected v=1 %h", m_valid, {m_rep, m_data}, exp_q[0]); end
    checks++; if ({h_valid, h_rep, h_data, h_errc} !== {1'b1, exp_q[0], 8'(exp_err)}) begin errors++; $display("FAIL post_reset_hi: got v=%b %h err=%0d expected v=1 %h err=%0d", h_valid, {h_rep, h_data}, h_errc, exp_q[0], exp_err); end
    code_ready = 1'b1; hold(1); code_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_repeat_codes();
    test_inverse_check();
    test_overflow();
    test_timeout();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
